// File: rtl/mux_n.sv
// N-to-1 single-bit multiplexer with a combinational output and a registered copy.
// The registered path also flags select values that fall outside the N data inputs.
module mux_n #(
    parameter  int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             y,
    input  logic [N-1:0]     x,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic             y_q,
    output logic             sel_err
);

    // One bit wider than sel so the bound still fits when N is exactly 2**SEL_W.
    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic yComb;
    logic selOutOfRange;
    logic yHold_q;
    logic yHold_d;
    logic selErr_q;
    logic selErr_d;

    // Any select value that matches no input leaves yComb at 0.
    always_comb begin
        yComb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                yComb = x[i];
            end
        end
    end

    assign selOutOfRange = ({1'b0, sel} >= N_EXT);

    always_comb begin
        yHold_d  = yHold_q;
        selErr_d = selErr_q;
        if (en) begin
            yHold_d  = yComb;
            selErr_d = selOutOfRange;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            yHold_q  <= 1'b0;
            selErr_q <= 1'b0;
        end else begin
            yHold_q  <= yHold_d;
            selErr_q <= selErr_d;
        end
    end

    assign y       = yComb;
    assign y_q     = yHold_q;
    assign sel_err = selErr_q;

endmodule

// File: tb/tb_mux_n.sv
// Drives five mux_n instances (N = 2, 3, 5, 8, 16) from one shared bus and
// compares them against a simple index-and-range reference model.
module tb_mux_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] xBus;
    logic [3:0]  selBus;

    logic [4:0] yAll;
    logic [4:0] yqAll;
    logic [4:0] errAll;

    logic [4:0] expYq;
    logic [4:0] expErr;

    int testCount = 0;
    int failCount = 0;

    int nList[5]    = '{2, 3, 5, 8, 16};
    int selWList[5] = '{1, 2, 3, 3, 4};

    always #5 clk = ~clk;

    mux_n #(.N(2)) u2 (
        .clk(clk), .reset(reset), .y(yAll[0]), .x(xBus[1:0]), .sel(selBus[0:0]),
        .en(en), .y_q(yqAll[0]), .sel_err(errAll[0])
    );
    mux_n #(.N(3)) u3 (
        .clk(clk), .reset(reset), .y(yAll[1]), .x(xBus[2:0]), .sel(selBus[1:0]),
        .en(en), .y_q(yqAll[1]), .sel_err(errAll[1])
    );
    mux_n #(.N(5)) u5 (
        .clk(clk), .reset(reset), .y(yAll[2]), .x(xBus[4:0]), .sel(selBus[2:0]),
        .en(en), .y_q(yqAll[2]), .sel_err(errAll[2])
    );
    mux_n #(.N(8)) u8 (
        .clk(clk), .reset(reset), .y(yAll[3]), .x(xBus[7:0]), .sel(selBus[2:0]),
        .en(en), .y_q(yqAll[3]), .sel_err(errAll[3])
    );
    mux_n #(.N(16)) u16 (
        .clk(clk), .reset(reset), .y(yAll[4]), .x(xBus[15:0]), .sel(selBus[3:0]),
        .en(en), .y_q(yqAll[4]), .sel_err(errAll[4])
    );

    function automatic int selSeen(int w, logic [3:0] sv);
        return int'(sv) & ((1 << w) - 1);
    endfunction

    function automatic logic refY(int n, int w, logic [15:0] xv, logic [3:0] sv);
        int s;
        s = selSeen(w, sv);
        if (s < n) return xv[s];
        return 1'b0;
    endfunction

    function automatic logic refErr(int n, int w, logic [3:0] sv);
        return (selSeen(w, sv) >= n);
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] xv, input logic [3:0] sv, input logic enV);
        xBus   = xv;
        selBus = sv;
        en     = enV;
        #1;
    endtask

    task automatic checkAllComb(input string tag);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s y N=%0d", tag, nList[i]), yAll[i],
                        refY(nList[i], selWList[i], xBus, selBus));
        end
    endtask

    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s y_q N=%0d", tag, nList[i]), yqAll[i], expYq[i]);
            checkOutput($sformatf("%s sel_err N=%0d", tag, nList[i]), errAll[i], expErr[i]);
        end
    endtask

    // Model updates from the inputs held across the edge, then everything is checked.
    task automatic clockEdge(input string tag);
        logic loadNow;
        loadNow = en && !reset;
        @(posedge clk);
        if (loadNow) begin
            for (int i = 0; i < 5; i++) begin
                expYq[i]  = refY(nList[i], selWList[i], xBus, selBus);
                expErr[i] = refErr(nList[i], selWList[i], selBus);
            end
        end
        #1;
        checkAllRegs(tag);
    endtask

    initial begin
        logic [7:0] pattern;
        logic [7:0] walkExpect;

        reset  = 1'b1;
        en     = 1'b0;
        xBus   = '0;
        selBus = '0;
        expYq  = '0;
        expErr = '0;
        #3;
        checkAllRegs("reset");

        @(negedge clk);
        reset = 1'b0;

        // Test 1: walk sel over a fixed pattern on the 8-input instance.
        pattern    = 8'b10101100;
        walkExpect = 8'b10101100;
        for (int s = 0; s < 8; s++) begin
            applyStimulus({8'h00, pattern}, 4'(s), 1'b0);
            checkOutput($sformatf("walk sel=%0d", s), yAll[3], walkExpect[s]);
            checkAllComb("walk");
        end

        // Test 2: only x[5] matters when sel=5.
        applyStimulus(16'h00DF, 4'd5, 1'b0);
        checkOutput("isolate x5=0", yAll[3], 1'b0);
        applyStimulus(16'h0020, 4'd5, 1'b0);
        checkOutput("isolate x5=1", yAll[3], 1'b1);
        applyStimulus(16'h00DF, 4'd5, 1'b0);
        checkOutput("isolate x5=0 again", yAll[3], 1'b0);

        // Test 3: load then hold.
        applyStimulus(16'h0004, 4'd2, 1'b1);
        clockEdge("load");
        checkOutput("load y_q N=8", yqAll[3], 1'b1);
        checkOutput("load sel_err N=8", errAll[3], 1'b0);
        applyStimulus(16'h0000, 4'd2, 1'b0);
        checkOutput("hold y N=8", yAll[3], 1'b0);
        clockEdge("hold");
        checkOutput("hold y_q N=8", yqAll[3], 1'b1);

        // Test 4: out-of-range select on the 5-input instance.
        applyStimulus(16'h001F, 4'd6, 1'b1);
        checkOutput("oor y N=5", yAll[2], 1'b0);
        clockEdge("oor");
        checkOutput("oor y_q N=5", yqAll[2], 1'b0);
        checkOutput("oor sel_err N=5", errAll[2], 1'b1);
        applyStimulus(16'h0010, 4'd4, 1'b1);
        checkOutput("edge y N=5", yAll[2], 1'b1);
        clockEdge("edge");
        checkOutput("edge sel_err N=5", errAll[2], 1'b0);
        checkOutput("edge y_q N=5", yqAll[2], 1'b1);

        // Test 5: asynchronous reset between edges, then reload.
        applyStimulus(16'h0040, 4'd6, 1'b1);
        clockEdge("preload");
        checkOutput("preload y_q N=8", yqAll[3], 1'b1);
        checkOutput("preload sel_err N=5", errAll[2], 1'b1);
        #2;
        reset = 1'b1;
        #1;
        expYq  = '0;
        expErr = '0;
        checkAllRegs("async reset");
        checkOutput("reset keeps y N=8", yAll[3], 1'b1);
        #1;
        reset = 1'b0;
        clockEdge("reload");
        checkOutput("reload y_q N=8", yqAll[3], 1'b1);
        checkOutput("reload sel_err N=5", errAll[2], 1'b1);

        // Test 6: random vectors across all instances, en mostly high.
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(16'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            checkAllComb("rand");
            clockEdge("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
